// File: rtl/stego_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding,
// default widths and a small width helper.
package stego_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_FF_WIDTH  = 8;
  localparam int DEF_MAX_BURST = 4;

  // Burst counter width; wide enough for the largest burst cap (255).
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Round-robin priority search: returns the one-hot position of the first
// set request bit found searching upward from ptr, wrapping around.
module rr_select
  import stego_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] sel
);

  // Walk the requesters starting at ptr and keep only the first hit.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ requesters. A requester is
// granted a burst of up to MAX_BURST words (or until its last word) and the
// round-robin pointer moves past it when the burst ends. Transfers stall
// while the FIFO reports full; nothing is dropped.
module fifo_wr_arbiter
  import stego_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int FF_WIDTH  = DEF_FF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*FF_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         ff_wren,
  output logic [FF_WIDTH-1:0]          ff_din,
  input  logic                         ff_full
);

  localparam int               PTR_W    = ptr_width(NUM_REQ);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  sel;
  logic [PTR_W-1:0]    g_idx;
  logic [FF_WIDTH-1:0] g_data;
  logic                g_valid;
  logic                g_last;
  logic [CNT_W-1:0]    cnt_inc;
  logic                xfer;
  logic                burst_done;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .sel (sel)
  );

  // Pick out the granted requester's index and lane; all zero when idle.
  always_comb begin
    g_idx   = '0;
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx   = PTR_W'(i);
        g_data  = req_data[i*FF_WIDTH +: FF_WIDTH];
        g_valid = req_valid[i];
        g_last  = req_last[i];
      end
    end
  end

  // A word moves when the owner presents one and the FIFO has room; the
  // burst closes on the owner's last word or when the cap is reached.
  always_comb begin
    cnt_inc    = cnt_q + CNT_W'(1);
    xfer       = (state_q == ST_BURST) && g_valid && !ff_full;
    burst_done = xfer && (g_last || (cnt_inc >= MAX_CNT));
  end

  // State register plus grant, pointer and burst count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: leave IDLE on any request, leave BURST when it closes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req_valid) state_d = ST_BURST;
      ST_BURST: if (burst_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant, pointer and counter updates; everything holds while stalled.
  always_comb begin
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (state_q == ST_IDLE) begin
      grant_d = (|req_valid) ? sel : '0;
      cnt_d   = '0;
    end else begin
      if (xfer && (cnt_q != MAX_CNT)) cnt_d = cnt_inc;
      if (burst_done) begin
        grant_d  = '0;
        rr_ptr_d = (g_idx == LAST_IDX) ? '0 : g_idx + PTR_W'(1);
      end
    end
  end

  // Output logic: the write port follows the owner, ready mirrors grant.
  always_comb begin
    grant     = grant_q;
    ff_wren   = xfer;
    ff_din    = (|grant_q) ? g_data : '0;
    req_ready = ff_full ? '0 : grant_q;
  end

endmodule
